// File: rtl/burst_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready sink among NUM_REQ fixed-length burst masters; grant locked per burst.
// One bubble cycle per burst for arbitration, then zero-latency pass-through; sink backpressure goes straight to the granted master.
module burst_rr_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int DATA_W    = 3,
  parameter int BURST_LEN = 3,
  localparam int GID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        sys_clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          valid_in,
  input  logic [NUM_REQ*DATA_W-1:0]   data_in,
  output logic [NUM_REQ-1:0]          ready_in,
  output logic                        valid_up,
  output logic [DATA_W-1:0]           data_up,
  input  logic                        ready_up,
  output logic [GID_W-1:0]            grant_id,
  output logic                        busy
);

  localparam int CNT_W = $clog2(BURST_LEN) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state, state_nxt;
  logic [GID_W-1:0]  grant_nxt;
  logic [GID_W-1:0]  rr_ptr, rr_ptr_nxt;
  logic [CNT_W-1:0]  beat_cnt, beat_cnt_nxt;
  logic [GID_W-1:0]  pick_idx, cand;
  logic              pick_vld;
  logic              active;
  logic              hs;
  logic [DATA_W-1:0] sel_dat;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state    <= IDLE;
      grant_id <= '0;
      rr_ptr   <= GID_W'(NUM_REQ - 1);
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant_id <= grant_nxt;
      rr_ptr   <= rr_ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  // First requester after the last finished master wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!pick_vld && valid_in[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant_id;
    rr_ptr_nxt   = rr_ptr;
    beat_cnt_nxt = beat_cnt;

    // Reset gates the outputs so a burst in flight is cut off in the reset cycle itself.
    active  = (state == BURST) && !rst;
    sel_dat = '0;
    ready_in = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == GID_W'(i)) begin
        sel_dat     = data_in[i*DATA_W +: DATA_W];
        ready_in[i] = active && ready_up;
      end
    end
    valid_up = active && valid_in[grant_id];
    data_up  = valid_up ? sel_dat : '0;
    hs       = valid_up && ready_up;
    busy     = active;

    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt    = BURST;
          grant_nxt    = pick_idx;
          beat_cnt_nxt = '0;
        end
      end
      BURST: begin
        if (hs) begin
          if (beat_cnt == LAST_BEAT) begin
            state_nxt    = IDLE;
            beat_cnt_nxt = '0;
            rr_ptr_nxt   = grant_id;
          end else begin
            beat_cnt_nxt = beat_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
